// File: rtl/mux_scan_seq.sv
// N-channel W-bit registered mux with single-shot select or round-robin auto-scan.
// Latency: 1 cycle from start (or channel advance) to dout_valid.
// Backpressure: dout/dout_ch are held while dout_valid && !dout_ready; the scan stalls.
module mux_scan_seq #(
  parameter int N_CH    = 8,
  parameter int W       = 8,
  parameter int DWELL_W = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] din,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   en_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic              start,
  input  logic              stop,
  output logic [W-1:0]      dout,
  output logic [SEL_W-1:0]  dout_ch,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              wrap
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DWELL} state_t;

  state_t             state;
  logic               scan_mode;
  logic               stop_pending;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] cnt;

  // Out-of-range indices (possible when N_CH is not a power of two) read as zero.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] d, input logic [SEL_W-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == idx) r = d[k*W +: W];
    end
    return r;
  endfunction

  // dout_ch doubles as the scan pointer: it always holds the last captured channel.
  logic             low_found;
  logic [SEL_W-1:0] low_idx;
  logic             nxt_found;
  logic [SEL_W-1:0] nxt_idx;
  logic [SEL_W-1:0] adv_idx;

  // Find the lowest enabled channel overall and the lowest one above the pointer.
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (en_mask[k]) begin
        low_found = 1'b1;
        low_idx   = SEL_W'(k);
        if (SEL_W'(k) > dout_ch) begin
          nxt_found = 1'b1;
          nxt_idx   = SEL_W'(k);
        end
      end
    end
    adv_idx = nxt_found ? nxt_idx : low_idx;
  end

  assign busy = (state != S_IDLE);

  // Control FSM with registered data path; wrap is a single-cycle pulse by default-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dout         <= '0;
      dout_ch      <= '0;
      dout_valid   <= 1'b0;
      wrap         <= 1'b0;
      scan_mode    <= 1'b0;
      stop_pending <= 1'b0;
      dwell_r      <= '0;
      cnt          <= '0;
    end else begin
      wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          // stop in the same cycle as start suppresses the start
          if (start && !stop) begin
            stop_pending <= 1'b0;
            dwell_r      <= dwell;
            scan_mode    <= mode;
            if (!mode) begin
              dout       <= pick(din, sel);
              dout_ch    <= sel;
              dout_valid <= 1'b1;
              state      <= S_PRESENT;
            end else if (low_found) begin
              dout       <= pick(din, low_idx);
              dout_ch    <= low_idx;
              dout_valid <= 1'b1;
              state      <= S_PRESENT;
            end
          end
        end

        S_PRESENT: begin
          if (dout_valid && dout_ready) begin
            if (!scan_mode || stop_pending || stop) begin
              dout_valid   <= 1'b0;
              stop_pending <= 1'b0;
              state        <= S_IDLE;
            end else if (dwell_r == '0) begin
              if (low_found) begin
                dout    <= pick(din, adv_idx);
                dout_ch <= adv_idx;
                wrap    <= !nxt_found;
              end else begin
                dout_valid <= 1'b0;
                state      <= S_IDLE;
              end
            end else begin
              dout_valid <= 1'b0;
              cnt        <= dwell_r;
              state      <= S_DWELL;
            end
          end else if (stop) begin
            stop_pending <= 1'b1;
          end
        end

        S_DWELL: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (cnt == DWELL_W'(1)) begin
            if (low_found) begin
              dout       <= pick(din, adv_idx);
              dout_ch    <= adv_idx;
              dout_valid <= 1'b1;
              wrap       <= !nxt_found;
              state      <= S_PRESENT;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq (N_CH=8, W=8); channel k carries 8'hA0+k.
// Each check compares the packed tuple {valid, busy, wrap, ch[2:0], dout[7:0]}.
module tb_mux_scan_seq;

  logic        clk;
  logic        rst_n;
  logic [63:0] din;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  en_mask;
  logic [3:0]  dwell;
  logic        start;
  logic        stop;
  logic [7:0]  dout;
  logic [2:0]  dout_ch;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  wire [13:0] obs = {dout_valid, busy, wrap, dout_ch, dout};

  mux_scan_seq #(.N_CH(8), .W(8), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel),
    .en_mask(en_mask), .dwell(dwell), .start(start), .stop(stop),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] exp_t(input logic v, input logic b, input logic w,
                                        input logic [2:0] ch, input logic [7:0] d);
    return {v, b, w, ch, d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; sel = '0; en_mask = '0; dwell = '0;
    start = 1'b0; stop = 1'b0; dout_ready = 1'b0;
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'hA0 + 8'(k);
    #3;
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd0, 8'h00)) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, exp_t(0, 0, 0, 3'd0, 8'h00));
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    mode = 1'b0; sel = 3'd5; dout_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    checks++;
    if (obs !== exp_t(1, 1, 0, 3'd5, 8'hA5)) begin
      errors++; $display("FAIL single_sel5: got %h expected %h", obs, exp_t(1, 1, 0, 3'd5, 8'hA5));
    end
    step();
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd5, 8'hA5)) begin
      errors++; $display("FAIL single_sel5_done: got %h expected %h", obs, exp_t(0, 0, 0, 3'd5, 8'hA5));
    end
    // held sample with backpressure; din for the held channel changes meanwhile
    sel = 3'd2; dout_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0; sel = 3'd6; din[2*8 +: 8] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_t(1, 1, 0, 3'd2, 8'hA2)) begin
        errors++; $display("FAIL single_hold cyc%0d: got %h expected %h", i, obs, exp_t(1, 1, 0, 3'd2, 8'hA2));
      end
      step();
    end
    din[2*8 +: 8] = 8'hA2;
    dout_ready = 1'b1;
    step();
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd2, 8'hA2)) begin
      errors++; $display("FAIL single_hold_release: got %h expected %h", obs, exp_t(0, 0, 0, 3'd2, 8'hA2));
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ch;
    mode = 1'b1; en_mask = 8'hFF; dwell = 4'd0; dout_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ch = 3'(i % 8);
      checks++;
      if (obs !== exp_t(1, 1, i == 8, ch, 8'hA0 + 8'(ch))) begin
        errors++; $display("FAIL b2b_sample%0d: got %h expected %h", i, obs, exp_t(1, 1, i == 8, ch, 8'hA0 + 8'(ch)));
      end
      if (i == 8) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd0, 8'hA0)) begin
      errors++; $display("FAIL b2b_stop_accept: got %h expected %h", obs, exp_t(0, 0, 0, 3'd0, 8'hA0));
    end
  endtask

  task automatic test_scan_dwell();
    logic [2:0] seq [4];
    seq[0] = 3'd1; seq[1] = 3'd4; seq[2] = 3'd7; seq[3] = 3'd1;
    mode = 1'b1; en_mask = 8'b1001_0010; dwell = 4'd2; dout_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0; dwell = 4'd9;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs !== exp_t(1, 1, j == 3, seq[j], 8'hA0 + 8'(seq[j]))) begin
        errors++; $display("FAIL dwell_sample%0d: got %h expected %h", j, obs, exp_t(1, 1, j == 3, seq[j], 8'hA0 + 8'(seq[j])));
      end
      if (j == 3) begin
        stop = 1'b1; step(); stop = 1'b0;
      end else begin
        for (int g = 0; g < 2; g++) begin
          step();
          checks++;
          if (obs !== exp_t(0, 1, 0, seq[j], 8'hA0 + 8'(seq[j]))) begin
            errors++; $display("FAIL dwell_gap%0d_%0d: got %h expected %h", j, g, obs, exp_t(0, 1, 0, seq[j], 8'hA0 + 8'(seq[j])));
          end
        end
        step();
      end
    end
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd1, 8'hA1)) begin
      errors++; $display("FAIL dwell_end: got %h expected %h", obs, exp_t(0, 0, 0, 3'd1, 8'hA1));
    end
  endtask

  task automatic test_backpressure_and_stop_dwell();
    mode = 1'b1; en_mask = 8'b1001_0010; dwell = 4'd2; dout_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp_t(1, 1, 0, 3'd4, 8'hA4)) begin
        errors++; $display("FAIL bp_hold cyc%0d: got %h expected %h", i, obs, exp_t(1, 1, 0, 3'd4, 8'hA4));
      end
      step();
    end
    dout_ready = 1'b1;
    step(); step(); step();
    checks++;
    if (obs !== exp_t(1, 1, 0, 3'd7, 8'hA7)) begin
      errors++; $display("FAIL bp_next_ch7: got %h expected %h", obs, exp_t(1, 1, 0, 3'd7, 8'hA7));
    end
    step();
    stop = 1'b1;
    step(); stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_t(0, 0, 0, 3'd7, 8'hA7)) begin
        errors++; $display("FAIL stop_dwell cyc%0d: got %h expected %h", i, obs, exp_t(0, 0, 0, 3'd7, 8'hA7));
      end
      step();
    end
  endtask

  task automatic test_stop_present();
    mode = 1'b1; en_mask = 8'hFF; dwell = 4'd1; dout_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    stop = 1'b1;
    step(); stop = 1'b0;
    step();
    checks++;
    if (obs !== exp_t(1, 1, 0, 3'd0, 8'hA0)) begin
      errors++; $display("FAIL stop_present_hold: got %h expected %h", obs, exp_t(1, 1, 0, 3'd0, 8'hA0));
    end
    dout_ready = 1'b1;
    step(); step();
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd0, 8'hA0)) begin
      errors++; $display("FAIL stop_present_idle: got %h expected %h", obs, exp_t(0, 0, 0, 3'd0, 8'hA0));
    end
  endtask

  task automatic test_ignored_starts();
    mode = 1'b1; en_mask = 8'h00; start = 1'b1;
    step(); start = 1'b0;
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd0, 8'hA0)) begin
      errors++; $display("FAIL empty_mask_start: got %h expected %h", obs, exp_t(0, 0, 0, 3'd0, 8'hA0));
    end
    mode = 1'b0; sel = 3'd3; start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd0, 8'hA0)) begin
      errors++; $display("FAIL start_stop_same: got %h expected %h", obs, exp_t(0, 0, 0, 3'd0, 8'hA0));
    end
  endtask

  task automatic test_single_channel_wrap();
    mode = 1'b1; en_mask = 8'b0000_1000; dwell = 4'd0; dout_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    checks++;
    if (obs !== exp_t(1, 1, 0, 3'd3, 8'hA3)) begin
      errors++; $display("FAIL one_ch_first: got %h expected %h", obs, exp_t(1, 1, 0, 3'd3, 8'hA3));
    end
    stop = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    checks++;
    if (obs !== exp_t(1, 1, 1, 3'd3, 8'hA3)) begin
      errors++; $display("FAIL one_ch_wrap: got %h expected %h", obs, exp_t(1, 1, 1, 3'd3, 8'hA3));
    end
    stop = 1'b1;
    step(); stop = 1'b0;
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd3, 8'hA3)) begin
      errors++; $display("FAIL one_ch_stop: got %h expected %h", obs, exp_t(0, 0, 0, 3'd3, 8'hA3));
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b0; sel = 3'd4; dout_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    checks++;
    if (obs !== exp_t(1, 1, 0, 3'd4, 8'hA4)) begin
      errors++; $display("FAIL areset_pre: got %h expected %h", obs, exp_t(1, 1, 0, 3'd4, 8'hA4));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== exp_t(0, 0, 0, 3'd0, 8'h00)) begin
      errors++; $display("FAIL areset_immediate: got %h expected %h", obs, exp_t(0, 0, 0, 3'd0, 8'h00));
    end
    #8 rst_n = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== exp_t(0, 0, 0, 3'd0, 8'h00)) begin
        errors++; $display("FAIL areset_quiet cyc%0d: got %h expected %h", i, obs, exp_t(0, 0, 0, 3'd0, 8'h00));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_scan_dwell();
    test_backpressure_and_stop_dwell();
    test_stop_present();
    test_ignored_starts();
    test_single_channel_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
